// File: rtl/writeback_unit.sv
// Writeback stage: round-robin picks one completed result per cycle from the
// execute pipes, registers it, then drives the register-file write and completion.
module writeback_unit #(
  parameter int p_num_pipes    = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [p_num_pipes-1:0]                        X_val,
  output logic [p_num_pipes-1:0]                        X_rdy,
  input  logic [p_num_pipes-1:0][31:0]                  X_pc,
  input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]    X_seq_num,
  input  logic [p_num_pipes-1:0][4:0]                   X_waddr,
  input  logic [p_num_pipes-1:0][31:0]                  X_wdata,
  input  logic [p_num_pipes-1:0]                        X_wen,
  output logic                                          rf_wen,
  output logic [4:0]                                    rf_waddr,
  output logic [31:0]                                   rf_wdata,
  output logic                                          cmpl_val,
  output logic [p_seq_num_bits-1:0]                     cmpl_seq_num,
  output logic [31:0]                                   cmpl_pc,
  output logic [4:0]                                    cmpl_waddr,
  output logic                                          cmpl_wen
);

  localparam int PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

  logic [PTR_W-1:0]          ptr;
  logic [PTR_W-1:0]          win;
  logic [PTR_W-1:0]          cand;
  logic [PTR_W-1:0]          ptr_next;
  logic                      found;

  logic                      wb_valid;
  logic [31:0]               wb_pc;
  logic [p_seq_num_bits-1:0] wb_seq_num;
  logic [4:0]                wb_waddr;
  logic [31:0]               wb_wdata;
  logic                      wb_wen;

  // Scan from ptr with wrap-around; the first valid channel wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < p_num_pipes; k++) begin
      cand = PTR_W'((int'(ptr) + k) % p_num_pipes);
      if (!found && X_val[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant is held off while reset is asserted so no handshake can be
  // accepted by a source while the flops are being cleared.
  always_comb begin
    X_rdy = '0;
    if (found && !rst) X_rdy[win] = 1'b1;
  end

  assign ptr_next = (win == PTR_W'(p_num_pipes - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      wb_seq_num <= '0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      wb_wen     <= 1'b0;
    end else begin
      wb_valid <= found;
      if (found) begin
        ptr        <= ptr_next;
        wb_pc      <= X_pc[win];
        wb_seq_num <= X_seq_num[win];
        wb_waddr   <= X_waddr[win];
        wb_wdata   <= X_wdata[win];
        wb_wen     <= X_wen[win];
      end
    end
  end

  // Writes to x0 are dropped at the register file but still reported as writes.
  assign rf_wen       = wb_valid & wb_wen & (wb_waddr != 5'd0);
  assign rf_waddr     = wb_waddr;
  assign rf_wdata     = wb_wdata;
  assign cmpl_val     = wb_valid;
  assign cmpl_seq_num = wb_seq_num;
  assign cmpl_pc      = wb_pc;
  assign cmpl_waddr   = wb_waddr;
  assign cmpl_wen     = wb_valid & wb_wen;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized-delay bench for writeback_unit with three pipes;
// expected results are queued when a source drives them and retired on completion.
module tb_writeback_unit;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      X_val;
  logic [2:0]      X_rdy;
  logic [2:0][31:0] X_pc;
  logic [2:0][4:0] X_seq_num;
  logic [2:0][4:0] X_waddr;
  logic [2:0][31:0] X_wdata;
  logic [2:0]      X_wen;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            cmpl_val;
  logic [4:0]      cmpl_seq_num;
  logic [31:0]     cmpl_pc;
  logic [4:0]      cmpl_waddr;
  logic            cmpl_wen;

  writeback_unit #(.p_num_pipes(3), .p_seq_num_bits(5)) dut (
    .clk(clk), .rst(rst),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
    .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cmpl_val(cmpl_val), .cmpl_seq_num(cmpl_seq_num), .cmpl_pc(cmpl_pc),
    .cmpl_waddr(cmpl_waddr), .cmpl_wen(cmpl_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int   testCount = 0;
  int   failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input bit push, input logic [31:0] pc,
                               input logic [4:0] seq, input logic [4:0] waddr,
                               input logic [31:0] wdata, input logic wen);
    exp_t e;
    X_val[ch]     = 1'b1;
    X_pc[ch]      = pc;
    X_seq_num[ch] = seq;
    X_waddr[ch]   = waddr;
    X_wdata[ch]   = wdata;
    X_wen[ch]     = wen;
    if (push) begin
      e.ch = ch; e.pc = pc; e.seq = seq; e.waddr = waddr; e.wdata = wdata; e.wen = wen;
      sb.push_back(e);
    end
  endtask

  task automatic dropValid(input logic [1:0] ch);
    X_val[ch] = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Retire the oldest outstanding entry of channel ch against the DUT outputs.
  task automatic checkCompletion(input string tag, input logic [1:0] ch);
    exp_t e;
    int   j;
    j = -1;
    for (int i = 0; i < sb.size(); i++)
      if (j < 0 && sb[i].ch == ch) j = i;
    testCount++;
    assert (j >= 0) else begin
      failCount++;
      $error("[TB] FAIL %s: observed completion on ch%0d expected none outstanding", tag, ch);
    end
    if (j >= 0) begin
      e = sb[j];
      sb.delete(j);
      checkOutput({tag, "_val"},   cmpl_val, 1);
      checkOutput({tag, "_seq"},   cmpl_seq_num, e.seq);
      checkOutput({tag, "_pc"},    cmpl_pc, e.pc);
      checkOutput({tag, "_cwa"},   cmpl_waddr, e.waddr);
      checkOutput({tag, "_rwa"},   rf_waddr, e.waddr);
      checkOutput({tag, "_wdata"}, rf_wdata, e.wdata);
      checkOutput({tag, "_cwen"},  cmpl_wen, e.wen);
      checkOutput({tag, "_rfwen"}, rf_wen, (e.wen && e.waddr != 5'd0));
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cval"}, cmpl_val, 0);
    checkOutput({tag, "_rfwen"}, rf_wen, 0);
    checkOutput({tag, "_cwen"}, cmpl_wen, 0);
  endtask

  int          sent[3];
  int          delay[3];
  bit          granted[3];
  int          completions;
  bit          done;
  logic [1:0]  dch;

  initial begin
    X_val = '0; X_pc = '0; X_seq_num = '0; X_waddr = '0; X_wdata = '0; X_wen = '0;
    rst = 1'b1;

    // Reset state, with two channels already valid for the contention case.
    applyStimulus(0, 1, 32'h100, 5'd1, 5'd1, 32'hA1, 1'b1);
    applyStimulus(1, 1, 32'h104, 5'd2, 5'd2, 32'hA2, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rdy", X_rdy, 0);
    checkIdle("rst");
    checkOutput("rst_rwa", rf_waddr, 0);
    checkOutput("rst_wdata", rf_wdata, 0);
    checkOutput("rst_pc", cmpl_pc, 0);
    checkOutput("rst_seq", cmpl_seq_num, 0);
    checkOutput("rst_cwa", cmpl_waddr, 0);
    nextCycle();
    rst = 1'b0;

    // Contention: ch0 then ch1 on consecutive cycles.
    @(negedge clk);
    checkOutput("cont_rdy0", X_rdy, 3'b001);
    nextCycle();
    dropValid(0);
    @(negedge clk);
    checkCompletion("cont_first", 0);
    checkOutput("cont_rdy1", X_rdy, 3'b010);
    nextCycle();
    dropValid(1);
    @(negedge clk);
    checkCompletion("cont_second", 1);
    checkOutput("cont_rdy_none", X_rdy, 0);

    // Single result on ch0 with a one-cycle completion pulse.
    nextCycle();
    applyStimulus(0, 1, 32'h200, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    checkOutput("single_rdy", X_rdy, 3'b001);
    nextCycle();
    dropValid(0);
    @(negedge clk);
    checkCompletion("single", 0);
    nextCycle();
    @(negedge clk);
    checkIdle("single_after");

    // x0 write then a no-write op back to back on ch1.
    nextCycle();
    applyStimulus(1, 1, 32'h300, 5'd4, 5'd0, 32'h1234, 1'b1);
    @(negedge clk);
    checkOutput("x0_rdy", X_rdy, 3'b010);
    nextCycle();
    applyStimulus(1, 1, 32'h304, 5'd5, 5'd7, 32'h5678, 1'b0);
    @(negedge clk);
    checkCompletion("x0", 1);
    checkOutput("nowr_rdy", X_rdy, 3'b010);
    nextCycle();
    dropValid(1);
    @(negedge clk);
    checkCompletion("nowrite", 1);
    nextCycle();
    @(negedge clk);
    checkIdle("nowrite_after");

    // Fairness: all channels continuously valid after a fresh reset.
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++)
      applyStimulus(2'(c), 1, 32'h1000 + 32'(c) * 32'h100, 5'(c * 2), 5'(c + 1), $urandom, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) checkCompletion("rr_cmpl", 2'((i - 1) % 3));
      checkOutput("rr_grant", X_rdy, 32'(1) << (i % 3));
      nextCycle();
      if (i < 3)
        applyStimulus(2'(i), 1, 32'h1004 + 32'(i) * 32'h100, 5'(i * 2 + 1), 5'(i + 2), $urandom, 1'b1);
      else
        dropValid(2'(i - 3));
    end
    @(negedge clk);
    checkCompletion("rr_last", 2);
    checkOutput("rr_sb_empty", sb.size(), 0);

    // Reset in the cycle after the seq 9 handshake discards it.
    nextCycle();
    applyStimulus(0, 0, 32'h400, 5'd9, 5'd3, 32'h99, 1'b1);
    @(negedge clk);
    checkOutput("rstmid_rdy", X_rdy, 3'b001);
    nextCycle();
    dropValid(0);
    rst = 1'b1;
    @(negedge clk);
    checkIdle("rstmid");
    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 1, 32'h500, 5'd10, 5'd4, 32'hB0, 1'b1);
    @(negedge clk);
    checkOutput("rstmid_ch1_rdy", X_rdy, 3'b010);
    nextCycle();
    dropValid(1);
    applyStimulus(0, 1, 32'h600, 5'd11, 5'd6, 32'hC0, 1'b1);
    applyStimulus(1, 1, 32'h604, 5'd12, 5'd8, 32'hC1, 1'b1);
    @(negedge clk);
    checkCompletion("rstmid_ch1", 1);
    checkOutput("rstmid_cont_rdy0", X_rdy, 3'b001);
    nextCycle();
    dropValid(0);
    @(negedge clk);
    checkCompletion("rstmid_cont0", 0);
    checkOutput("rstmid_cont_rdy1", X_rdy, 3'b010);
    nextCycle();
    dropValid(1);
    @(negedge clk);
    checkCompletion("rstmid_cont1", 1);

    // Streaming with random source gaps, 20 results per channel.
    for (int c = 0; c < 3; c++) begin
      sent[c] = 0;
      delay[c] = $urandom_range(0, 3);
      granted[c] = 1'b0;
    end
    completions = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      nextCycle();
      for (int c = 0; c < 3; c++) begin
        if (X_val[c] && granted[c]) begin
          dropValid(2'(c));
          sent[c]++;
          delay[c] = $urandom_range(0, 3);
        end
        if (!X_val[c] && sent[c] < 20) begin
          if (delay[c] == 0)
            applyStimulus(2'(c), 1, 32'h1000 + 32'(c) * 32'h100 + 32'(sent[c]) * 4,
                          5'((c * 20 + sent[c]) % 32), 5'((sent[c] + c) % 8),
                          $urandom, (sent[c] % 5) != 0);
          else
            delay[c]--;
        end
      end
      @(negedge clk);
      for (int c = 0; c < 3; c++) granted[c] = X_rdy[c];
      checkOutput("stream_rdy_subset", X_rdy & ~X_val, 0);
      checkOutput("stream_rdy_onehot", $onehot0(X_rdy), 1);
      if (cmpl_val) begin
        dch = cmpl_pc[9:8];
        checkCompletion("stream", dch);
        completions++;
      end
      done = (sent[0] == 20) && (sent[1] == 20) && (sent[2] == 20) && (sb.size() == 0);
    end
    checkOutput("stream_done", done, 1);
    checkOutput("stream_count", completions, 60);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the pipeline: collects completed results from `p_num_pipes` execute units (ALU, multiplier, memory, ...) over X__W val/rdy channels. It selects one per cycle with round-robin arbitration and registers it. The following cycle it drives the register-file write port and a one-cycle completion notification back to the decode-stage scoreboard. It never applies backpressure beyond arbitration losses and sustains one result per cycle.

## Interface
- `p_num_pipes`, 2, number of X__W input channels (2..8)
- `p_seq_num_bits`, 5, width of sequence numbers
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `X_val`  in  p_num_pipes  per-channel result valid
- `X_rdy`  out  p_num_pipes  per-channel ready (grant)
- `X_pc`  in  p_num_pipes×32  per-channel PC
- `X_seq_num`  in  p_num_pipes×p_seq_num_bits  per-channel sequence number
- `X_waddr`  in  p_num_pipes×5  per-channel destination register
- `X_wdata`  in  p_num_pipes×32  per-channel result data
- `X_wen`  in  p_num_pipes  per-channel write enable
- `rf_wen`  out  1  register-file write enable
- `rf_waddr`  out  5  register-file write address
- `rf_wdata`  out  32  register-file write data
- `cmpl_val`  out  1  completion pulse to scoreboard
- `cmpl_seq_num`  out  p_seq_num_bits  completed sequence number
- `cmpl_pc`  out  32  completed PC
- `cmpl_waddr`  out  5  destination released (valid when `cmpl_wen`)
- `cmpl_wen`  out  1  completed op wrote a register

## Operation
- State:
  - round-robin pointer `ptr` (log2 p_num_pipes bits);
  - writeback register `wb_*`, holding valid, pc, seq_num, waddr, wdata and wen.
- Arbitration (combinational, each cycle):
  - Scan channels starting at `ptr`, wrapping modulo `p_num_pipes`.
  - The first channel with `X_val=1` wins; `X_rdy[win]=1`, all others 0.
  - With no valid channel, all `X_rdy=0`.
  - `X_rdy` depends on `X_val`; `X_val` must not depend on `X_rdy` (channel contract).
- On a handshake (`X_val[i] & X_rdy[i]`):
  - Capture channel i fields into `wb_*` and set `wb_valid=1`.
  - Set `ptr <= (i+1) mod p_num_pipes`.
- With no handshake: `wb_valid <= 0` and `ptr` holds.
- Outputs, driven from `wb_*` only (registered, no comb path from inputs):
  - `rf_wen = wb_valid & wb_wen & (wb_waddr != 0)`;
  - `rf_waddr = wb_waddr`, `rf_wdata = wb_wdata`;
  - `cmpl_val = wb_valid`;
  - `cmpl_seq_num`, `cmpl_pc`, `cmpl_waddr` from `wb_*`;
  - `cmpl_wen = wb_valid & wb_wen`.
- x0 handling: a write to x0 is suppressed at the register file, but still completes with `cmpl_wen=1`, `cmpl_waddr=0`.
- An op with `X_wen=0` (branch/store) completes with `rf_wen=0`, `cmpl_wen=0`.
- No reordering: results complete in grant order. Program order is the scoreboard's concern.

## Timing
- Reset (async assert, sync deassert at the flops):
  - `ptr=0`, `wb_valid=0`, all `wb_*` fields 0;
  - hence every output is 0, including `X_rdy` during reset.
- Latency: handshake in cycle N → `rf_wen` / `cmpl_val` high for exactly cycle N+1.
- Throughput: one result per cycle. Back-to-back handshakes give back-to-back completion pulses.
- Simultaneous valids: exactly one grant per cycle. A losing channel must hold `val` and its fields stable until granted.
- Starvation bound: a continuously valid channel is granted within `p_num_pipes` cycles.
- Pointer wrap: a grant to channel `p_num_pipes-1` sets `ptr=0`.
- Reset mid-operation:
  - a pending `wb_valid` is discarded; no register-file write or completion for it;
  - arbitration restarts at channel 0.

## Test plan
- Single result: channel 0 sends pc=0x200, seq=3, waddr=5, wdata=0xDEADBEEF, wen=1 at cycle N → `X_rdy[0]=1` at N. At N+1: `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, `cmpl_val=1`, `cmpl_seq_num=3`. At N+2 all zero.
- Contention (p_num_pipes=2): both channels valid from reset with seq 1 (ch0) and seq 2 (ch1) → grant ch0 then ch1. `cmpl_seq_num` is 1 then 2 on consecutive cycles; `ptr` returns to 0.
- Round-robin fairness (p_num_pipes=3): all channels continuously valid for 6 cycles → grant order 0,1,2,0,1,2. No channel waits more than 3 cycles.
- x0 and no-write: waddr=0, wen=1, wdata=0x1234 → `rf_wen=0`, `cmpl_val=1`, `cmpl_wen=1`, `cmpl_waddr=0`. Then wen=0, waddr=7 → `rf_wen=0`, `cmpl_wen=0`, `cmpl_val=1`.
- Streaming with delays: random source delays 0–3 cycles and 20 results per channel → every seq_num completes exactly once with matching pc/waddr/wdata. Each channel's results appear in order.
- Reset mid-operation: assert `rst` in the cycle after a handshake with seq=9 → no `rf_wen` or `cmpl_val` for seq 9. After deassert, ch1-only traffic is still granted immediately, and a subsequent two-channel contention starts with ch0.
